rtc_write_sequencer: RTL and testbench

- Upstream controller for the RTC write-cycle FSM.
- Turns a high-level request into an ordered series of single-register writes:
  - "init": oscillator and control setup.
  - "update": load the time/date fields.
- For each write it presents wr_addr/wr_data, pulses wr_start (which drives the write FSM's `in`) and waits for that FSM's one-cycle write_end before starting the next write.
- Includes a watchdog that aborts a hung write.

---
 rtl/rtc_pkg.sv | 42 ++++
 rtl/rtc_write_table.sv | 43 ++++
 rtl/rtc_write_sequencer.sv | 137 +++++++++++++
 tb/tb_rtc_write_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC write sequencer: FSM states, sequence selects,
// RTC register map and control bytes.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    typedef enum logic {
        SEQ_INIT = 1'b0,
        SEQ_UPD  = 1'b1
    } seq_t;

    localparam logic [7:0] REG_SEC   = 8'h00;
    localparam logic [7:0] REG_MIN   = 8'h02;
    localparam logic [7:0] REG_HOUR  = 8'h04;
    localparam logic [7:0] REG_DATE  = 8'h07;
    localparam logic [7:0] REG_MONTH = 8'h08;
    localparam logic [7:0] REG_YEAR  = 8'h09;
    localparam logic [7:0] REG_A     = 8'h0A;
    localparam logic [7:0] REG_B     = 8'h0B;

    localparam logic [7:0] CTRL_SET = 8'h82;
    localparam logic [7:0] CTRL_RUN = 8'h02;
    localparam logic [7:0] OSC_ON   = 8'h20;

    typedef struct packed {
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic [7:0] date;
        logic [7:0] month;
        logic [7:0] year;
    } rtc_time_t;

endpackage

// File: rtl/rtc_write_table.sv
// Combinational write table: (sequence, step, time snapshot) -> register
// address, data byte and last-entry flag.
module rtc_write_table
    import rtc_pkg::*;
(
    input  logic        i_seq,
    input  logic [2:0]  i_step,
    input  logic [47:0] i_snap,
    output logic [7:0]  o_addr,
    output logic [7:0]  o_data,
    output logic        o_last
);

    rtc_time_t w_snap;
    assign w_snap = rtc_time_t'(i_snap);

    always_comb begin
        o_addr = '0;
        o_data = '0;
        o_last = 1'b1;
        if (i_seq == logic'(SEQ_INIT)) begin
            case (i_step)
                3'd0: begin o_addr = REG_B; o_data = CTRL_SET; o_last = 1'b0; end
                3'd1: begin o_addr = REG_A; o_data = OSC_ON;   o_last = 1'b0; end
                3'd2: begin o_addr = REG_B; o_data = CTRL_RUN; o_last = 1'b1; end
                default: ;
            endcase
        end else begin
            case (i_step)
                3'd0: begin o_addr = REG_B;     o_data = CTRL_SET;      o_last = 1'b0; end
                3'd1: begin o_addr = REG_SEC;   o_data = w_snap.sec;    o_last = 1'b0; end
                3'd2: begin o_addr = REG_MIN;   o_data = w_snap.min;    o_last = 1'b0; end
                3'd3: begin o_addr = REG_HOUR;  o_data = w_snap.hour;   o_last = 1'b0; end
                3'd4: begin o_addr = REG_DATE;  o_data = w_snap.date;   o_last = 1'b0; end
                3'd5: begin o_addr = REG_MONTH; o_data = w_snap.month;  o_last = 1'b0; end
                3'd6: begin o_addr = REG_YEAR;  o_data = w_snap.year;   o_last = 1'b0; end
                3'd7: begin o_addr = REG_B;     o_data = CTRL_RUN;      o_last = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Sequences init / time-update register writes into the RTC write-cycle FSM,
// one write at a time, with a watchdog on each write's completion.
module rtc_write_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       upd_req,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic [7:0] date,
    input  logic [7:0] month,
    input  logic [7:0] year,
    input  logic       write_end,
    output logic       wr_start,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    seq_t       r_seq;
    logic [2:0] r_step;
    logic       r_pending;
    rtc_time_t  r_snap;
    logic [15:0] r_cnt;
    logic       r_err;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    logic [7:0] w_tbl_addr;
    logic [7:0] w_tbl_data;
    logic       w_tbl_last;

    rtc_write_table u_table (
        .i_seq  (r_seq),
        .i_step (r_step),
        .i_snap (r_snap),
        .o_addr (w_tbl_addr),
        .o_data (w_tbl_data),
        .o_last (w_tbl_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        wr_start = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (init_req || upd_req || r_pending) w_next = ST_LOAD;
            end
            ST_LOAD:  w_next = ST_START;
            ST_START: begin
                wr_start = 1'b1;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (write_end)             w_next = ST_NEXT;
                else if (r_cnt == TO_LAST) w_next = ST_ERR;
            end
            ST_NEXT:  w_next = w_tbl_last ? ST_DONE : ST_LOAD;
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq     <= SEQ_INIT;
            r_step    <= '0;
            r_pending <= 1'b0;
            r_snap    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            // Busy-time update requests merge into a single pending flag; ERR drops it.
            if (r_state != ST_IDLE && upd_req) r_pending <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (init_req) begin
                        r_seq  <= SEQ_INIT;
                        r_step <= '0;
                        r_err  <= 1'b0;
                        if (upd_req) r_pending <= 1'b1;
                    end else if (upd_req || r_pending) begin
                        r_seq     <= SEQ_UPD;
                        r_step    <= '0;
                        r_snap    <= {sec, min, hour, date, month, year};
                        r_pending <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_addr <= w_tbl_addr;
                    r_data <= w_tbl_data;
                    r_cnt  <= '0;
                end
                ST_WAIT: r_cnt <= r_cnt + 16'd1;
                ST_NEXT: if (!w_tbl_last) r_step <= r_step + 3'd1;
                ST_ERR: begin
                    r_err     <= 1'b1;
                    r_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wr_addr = r_addr;
    assign wr_data = r_data;
    assign err     = r_err;
    assign state   = r_state;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: stimulus pushes expected writes,
// a monitor pops and checks them on every wr_start pulse.
module tb_rtc_write_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_req = 1'b0;
    logic       upd_req = 1'b0;
    logic [7:0] sec = 8'h00, min = 8'h00, hour = 8'h00;
    logic [7:0] date = 8'h00, month = 8'h00, year = 8'h00;
    logic       write_end = 1'b0;
    logic       wr_start;
    logic [7:0] wr_addr, wr_data;
    logic       busy, done, err;
    logic [2:0] state;

    rtc_write_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .upd_req(upd_req),
        .sec(sec), .min(min), .hour(hour), .date(date), .month(month), .year(year),
        .write_end(write_end), .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    int pulses = 0;
    int dones = 0;
    int resp_delay = 8;   // 0 = never answer
    int rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-FSM model: write_end high during cycle S+resp_delay for wr_start in cycle S.
    initial begin
        forever begin
            @(negedge clk);
            write_end = 1'b0;
            if (rst) rsp_cnt = 0;
            else begin
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) write_end = 1'b1;
                end
                if (wr_start && resp_delay > 0) rsp_cnt = resp_delay;
            end
        end
    end

    initial begin
        logic [15:0] e;
        logic chk_next;
        chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                check("busy_after_done", busy, 1'b0);
                chk_next = 1'b0;
            end
            if (wr_start) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_wr_start: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e[15:8]);
                    check("wr_data", wr_data, e[7:0]);
                end
            end
            if (done) begin
                dones++;
                chk_next = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0B82);
        exp_q.push_back(16'h0A20);
        exp_q.push_back(16'h0B02);
    endtask

    task automatic push_upd(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                            input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
        exp_q.push_back(16'h0B82);
        exp_q.push_back({8'h00, s});
        exp_q.push_back({8'h02, m});
        exp_q.push_back({8'h04, h});
        exp_q.push_back({8'h07, d});
        exp_q.push_back({8'h08, mo});
        exp_q.push_back({8'h09, y});
        exp_q.push_back(16'h0B02);
    endtask

    task automatic req(input logic i, input logic u);
        init_req = i;
        upd_req  = u;
        @(negedge clk);
        init_req = 1'b0;
        upd_req  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (dones < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        tick(2);
        check("done_count", dones, target);
    endtask

    task automatic wait_idle(input int budget, output int wait_cycles);
        int k;
        k = 0;
        wait_cycles = 0;
        while (busy && k < budget) begin
            if (state == 3'd3) wait_cycles++;
            @(negedge clk);
            k++;
        end
        check("seq_finished_busy", busy, 1'b0);
    endtask

    initial begin
        int p0, d0, wc, k;
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int p0, d0, wc, k;

        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_state", state, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_start", wr_start, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        check("rst_wr_data", wr_data, 8'h00);

        // init sequence
        p0 = pulses; d0 = dones;
        push_init();
        req(1'b1, 1'b0);
        check("init_load_state", state, 3'd1);
        wait_done(d0 + 1, 200);
        check("init_pulses", pulses - p0, 3);
        check("init_err", err, 1'b0);

        // update sequence with latency check and mid-sequence field change
        sec = 8'h45; min = 8'h30; hour = 8'h12; date = 8'h15; month = 8'h09; year = 8'h16;
        p0 = pulses; d0 = dones;
        push_upd(8'h45, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
        req(1'b0, 1'b1);
        check("upd_lat_load", state, 3'd1);
        check("upd_lat_nostart", wr_start, 1'b0);
        tick(1);
        check("upd_lat_start", wr_start, 1'b1);
        sec = 8'h00;
        wait_done(d0 + 1, 300);
        check("upd_pulses", pulses - p0, 8);

        // simultaneous init+upd: INIT first, then pending UPD
        p0 = pulses; d0 = dones;
        push_init();
        push_upd(8'h00, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
        req(1'b1, 1'b1);
        wait_done(d0 + 2, 500);
        check("both_pulses", pulses - p0, 11);

        // watchdog: write_end never returned
        resp_delay = 0;
        p0 = pulses; d0 = dones;
        exp_q.push_back(16'h0B82);
        req(1'b0, 1'b1);
        wait_idle(100, wc);
        check("to_wait_cycles", wc, 16);
        check("to_err", err, 1'b1);
        check("to_state", state, 3'd0);
        check("to_no_done", dones, d0);
        check("to_pulses", pulses - p0, 1);

        // recovery clears err
        resp_delay = 8;
        d0 = dones;
        push_upd(8'h00, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
        req(1'b0, 1'b1);
        check("recover_err_clr", err, 1'b0);
        wait_done(d0 + 1, 300);
        check("recover_err", err, 1'b0);

        // write_end on the last allowed WAIT cycle
        resp_delay = 16;
        p0 = pulses; d0 = dones;
        push_init();
        req(1'b1, 1'b0);
        wait_done(d0 + 1, 300);
        check("edge_err", err, 1'b0);
        check("edge_pulses", pulses - p0, 3);

        // one cycle late -> timeout
        resp_delay = 17;
        d0 = dones;
        exp_q.push_back(16'h0B82);
        req(1'b1, 1'b0);
        wait_idle(100, wc);
        check("late_wait_cycles", wc, 16);
        check("late_err", err, 1'b1);
        check("late_no_done", dones, d0);

        // reset during the 4th update write, with an update pending
        resp_delay = 8;
        p0 = pulses;
        exp_q.push_back(16'h0B82);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0230);
        exp_q.push_back(16'h0412);
        req(1'b0, 1'b1);
        k = 0;
        while (pulses < p0 + 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tick(2);
        upd_req = 1'b1;
        tick(1);
        upd_req = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_state", state, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_wr_start", wr_start, 1'b0);
        check("mid_rst_wr_addr", wr_addr, 8'h00);
        check("mid_rst_err", err, 1'b0);
        tick(40);
        check("mid_rst_no_writes", pulses - p0, 4);
        check("mid_rst_idle", busy, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
